// File: rtl/fifo_pkg.sv
// Shared constants and types for the narrow-to-wide packing FIFO (fifo_n2w).
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH_DEF;

  // Occupancy counter spans 0..DEPTH inclusive, hence one extra bit.
  typedef logic [ADDR_WIDTH_DEF:0] count_t;

endpackage

// File: rtl/fifo_n2w_if.sv
// Handshake bundle for fifo_n2w: nibble write side, packed-word read side.
interface fifo_n2w_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
) ();

  logic                      wr;
  logic [DATA_WIDTH-1:0]     w_data;
  logic                      rd;
  logic [2*DATA_WIDTH-1:0]   r_data;
  logic                      full;
  logic                      empty;

  // FIFO side
  modport slave (
    input  wr,
    input  w_data,
    input  rd,
    output r_data,
    output full,
    output empty
  );

  // Producer/consumer side
  modport master (
    output wr,
    output w_data,
    output rd,
    input  r_data,
    input  full,
    input  empty
  );

endinterface

// File: rtl/fifo_n2w_ctrl.sv
// Pointer, occupancy and flag control for fifo_n2w.
// Write pointer advances one nibble per write; read pointer advances one
// word (two nibbles) per read and therefore always stays even.
module fifo_n2w_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr,
  output logic                  we,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned          CAP   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  CAP_C = CAP[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]  C_ONE = 1;
  localparam logic [ADDR_WIDTH:0]  C_TWO = 2;
  localparam logic [ADDR_WIDTH-1:0] P_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] P_TWO = 2;

  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] count_next;
  logic                write_ok;
  logic                read_ok;

  // Acceptance is judged on the registered flags; next occupancy follows.
  always_comb begin
    write_ok   = wr & ~full;
    read_ok    = rd & ~empty;
    count_next = count;
    unique case ({write_ok, read_ok})
      2'b10:   count_next = count + C_ONE;
      2'b01:   count_next = count - C_TWO;
      2'b11:   count_next = count - C_ONE;
      default: count_next = count;
    endcase
  end

  assign we = write_ok;

  // Pointer/count state and flags registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (write_ok) w_ptr <= w_ptr + P_ONE;
      if (read_ok)  r_ptr <= r_ptr + P_TWO;
      count <= count_next;
      full  <= (count_next == CAP_C);
      empty <= (count_next < C_TWO);
    end
  end

endmodule

// File: rtl/fifo_n2w.sv
// Narrow-to-wide packing FIFO: one DATA_WIDTH nibble in per write, one
// 2*DATA_WIDTH word out per read, built from the two oldest nibbles.
// Read data is show-ahead, taken combinationally from the register file.
// Build option FIFO_N2W_MSB_FIRST_EN: first-written nibble lands in the
// upper half of r_data instead of the lower half.
module fifo_n2w
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  fifo_n2w_if.slave  bus
);

  localparam int unsigned           NSLOT = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] P_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [NSLOT];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr_hi;
  logic                  we;
  logic [DATA_WIDTH-1:0] first_nib;
  logic [DATA_WIDTH-1:0] second_nib;

  fifo_n2w_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .wr    (bus.wr),
    .rd    (bus.rd),
    .w_ptr (w_ptr),
    .r_ptr (r_ptr),
    .we    (we),
    .full  (bus.full),
    .empty (bus.empty)
  );

  // Write port: storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[w_ptr] <= bus.w_data;
  end

  // Two-nibble read mux; r_ptr is even so the pair never straddles a word.
  always_comb begin
    r_ptr_hi   = r_ptr + P_ONE;
    first_nib  = mem[r_ptr];
    second_nib = mem[r_ptr_hi];
`ifdef FIFO_N2W_MSB_FIRST_EN
    bus.r_data = {first_nib, second_nib};
`else
    bus.r_data = {second_nib, first_nib};
`endif
  end

endmodule

// File: tb/tb_fifo_n2w.sv
// Directed bench for fifo_n2w with a nibble-queue scoreboard.
module tb_fifo_n2w;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [3:0] q[$];

  fifo_n2w_if #(.DATA_WIDTH(4)) bus ();

  fifo_n2w #(
    .DATA_WIDTH (4),
    .ADDR_WIDTH (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second);
`ifdef FIFO_N2W_MSB_FIRST_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on negedge, check show-ahead data, update model, check flags.
  task automatic step(input logic w, input logic [3:0] d, input logic r);
    int unsigned cnt;
    logic wok, rok;
    @(negedge clk);
    bus.wr = w; bus.w_data = d; bus.rd = r;
    cnt = q.size();
    if (cnt >= 2) chk("show_ahead", {24'h0, bus.r_data}, {24'h0, pack(q[0], q[1])});
    wok = w && (cnt != 8);
    rok = r && (cnt >= 2);
    @(posedge clk);
    if (rok) begin void'(q.pop_front()); void'(q.pop_front()); end
    if (wok) q.push_back(d);
    #1;
    bus.wr = 1'b0; bus.rd = 1'b0;
    chk("full",  {31'h0, bus.full},  {31'h0, q.size() == 8});
    chk("empty", {31'h0, bus.empty}, {31'h0, q.size() < 2});
    chk("count", {28'h0, dut.u_ctrl.count}, q.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    reset = 1'b0;
    chk("rst_full",  {31'h0, bus.full},  32'h0);
    chk("rst_empty", {31'h0, bus.empty}, 32'h1);
    chk("rst_count", {28'h0, dut.u_ctrl.count}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0;
    do_reset();

    // Basic pair
    step(1, 4'h1, 0);
    chk("one_nib_empty", {31'h0, bus.empty}, 32'h1);
    step(1, 4'h2, 0);
    chk("pair_empty", {31'h0, bus.empty}, 32'h0);
    chk("pair_data", {24'h0, bus.r_data}, {24'h0, pack(4'h1, 4'h2)});
    step(0, 4'h0, 1);
    chk("pair_drained", {31'h0, bus.empty}, 32'h1);

    // Odd nibble held across an ignored read
    step(1, 4'h3, 0);
    step(0, 4'h0, 1);
    chk("odd_kept", {28'h0, dut.u_ctrl.count}, 32'h1);
    step(1, 4'h4, 0);
    chk("odd_data", {24'h0, bus.r_data}, {24'h0, pack(4'h3, 4'h4)});
    step(0, 4'h0, 1);

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0);
    chk("fill_full", {31'h0, bus.full}, 32'h1);
    step(1, 4'h9, 0);
    chk("ovf_count", {28'h0, dut.u_ctrl.count}, 32'h8);
    for (int i = 0; i < 4; i++) begin
      chk("drain_word", {24'h0, bus.r_data}, {24'h0, pack(4'(2*i+1), 4'(2*i+2))});
      step(0, 4'h0, 1);
    end
    chk("drain_empty", {31'h0, bus.empty}, 32'h1);

    // wr+rd while full: read wins, write dropped
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0);
    step(1, 4'hA, 1);
    chk("fullrw_full",  {31'h0, bus.full}, 32'h0);
    chk("fullrw_count", {28'h0, dut.u_ctrl.count}, 32'h6);
    chk("fullrw_next",  {24'h0, bus.r_data}, {24'h0, pack(4'h3, 4'h4)});
    for (int i = 0; i < 3; i++) step(0, 4'h0, 1);

    // wr+rd with one nibble stored: write only
    step(1, 4'h5, 0);
    step(1, 4'h6, 1);
    chk("oddrw_count", {28'h0, dut.u_ctrl.count}, 32'h2);
    chk("oddrw_data", {24'h0, bus.r_data}, {24'h0, pack(4'h5, 4'h6)});
    for (int i = 0; i < 3; i++) step(1, 4'($urandom_range(0, 15)), 0);

    // Mixed traffic across pointer wrap
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    while (q.size() >= 2) step(0, 4'h0, 1);

    // wr+rd with zero stored
    if (q.size() == 1) step(0, 4'h0, 1);
    do_reset();
    step(1, 4'h7, 1);
    chk("zero_rw_count", {28'h0, dut.u_ctrl.count}, 32'h1);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) step(1, 4'(i + 8), 0);
    chk("pre_rst_count", {28'h0, dut.u_ctrl.count}, 32'h5);
    do_reset();
    step(1, 4'hB, 0);
    step(1, 4'hC, 0);
    chk("post_rst_data", {24'h0, bus.r_data}, {24'h0, pack(4'hB, 4'hC)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
